// File: rtl/compare_alarm_if.sv
// Sample/flag stream from the magnitude comparator and the qualified alarm/status
// returned by compare_alarm_fsm.
interface compare_alarm_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       sample;
  logic             equal;
  logic             greater;
  logic             less;
  logic             clear;
  logic             alarm;
  logic             alarm_rise;
  logic             alarm_fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] over_count;
  logic [7:0]       peak;
  logic             flag_err;

  modport master (
    output in_valid, sample, equal, greater, less, clear,
    input  alarm, alarm_rise, alarm_fall, state, over_count, peak, flag_err
  );

  modport slave (
    input  in_valid, sample, equal, greater, less, clear,
    output alarm, alarm_rise, alarm_fall, state, over_count, peak, flag_err
  );
endinterface

// File: rtl/compare_alarm_fsm.sv
// Debounced over-threshold alarm with hysteresis, driven by comparator flags,
// plus saturating over-threshold count and peak-sample status.
//
// state    | meaning
// IDLE     | no alarm, no run in progress
// ARMING   | counting consecutive greater samples toward HI_COUNT
// ALARM    | alarm asserted
// CLEARING | alarm asserted, counting consecutive less samples toward LO_COUNT
module compare_alarm_fsm #(
  parameter int HI_COUNT = 4,
  parameter int LO_COUNT = 4,
  parameter int CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  compare_alarm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  state_t           state_q, state_nx;
  logic [3:0]       run_q, run_nx;
  logic             rise_q, rise_nx;
  logic             fall_q, fall_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [7:0]       peak_q, peak_nx;
  logic             err_q, err_nx;

  logic       flags_ok;
  logic       accept;
  logic [3:0] run_inc;

  assign flags_ok = ({bus.equal, bus.greater, bus.less} == 3'b100) ||
                    ({bus.equal, bus.greater, bus.less} == 3'b010) ||
                    ({bus.equal, bus.greater, bus.less} == 3'b001);
  assign accept   = bus.in_valid && flags_ok;
  assign run_inc  = run_q + 4'd1;

  always_comb begin
    state_nx = state_q;
    run_nx   = run_q;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    cnt_nx   = cnt_q;
    peak_nx  = peak_q;
    err_nx   = err_q;

    if (bus.in_valid && !flags_ok) err_nx = 1'b1;

    if (accept) begin
      if (bus.greater) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_nx = cnt_q + 1'b1;
        if (bus.sample > peak_q) peak_nx = bus.sample;
      end

      case (state_q)
        IDLE: begin
          if (bus.greater) begin
            state_nx = ARMING;
            run_nx   = 4'd1;
          end
        end
        ARMING: begin
          if (bus.greater) begin
            if (run_inc == 4'(HI_COUNT)) begin
              state_nx = ALARM;
              run_nx   = 4'd0;
              rise_nx  = 1'b1;
            end else begin
              run_nx = run_inc;
            end
          end else begin
            state_nx = IDLE;
            run_nx   = 4'd0;
          end
        end
        ALARM: begin
          if (bus.less) begin
            state_nx = CLEARING;
            run_nx   = 4'd1;
          end
        end
        CLEARING: begin
          if (bus.less) begin
            if (run_inc == 4'(LO_COUNT)) begin
              state_nx = IDLE;
              run_nx   = 4'd0;
              fall_nx  = 1'b1;
            end else begin
              run_nx = run_inc;
            end
          end else begin
            state_nx = ALARM;
            run_nx   = 4'd0;
          end
        end
        default: begin
          state_nx = IDLE;
          run_nx   = 4'd0;
        end
      endcase
    end
  end

  // clear behaves as reset and swallows any sample presented alongside it
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q <= IDLE;
      run_q   <= 4'd0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      peak_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      run_q   <= run_nx;
      rise_q  <= rise_nx;
      fall_q  <= fall_nx;
      cnt_q   <= cnt_nx;
      peak_q  <= peak_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.alarm      = (state_q == ALARM) || (state_q == CLEARING);
  assign bus.alarm_rise = rise_q;
  assign bus.alarm_fall = fall_q;
  assign bus.state      = state_q;
  assign bus.over_count = cnt_q;
  assign bus.peak       = peak_q;
  assign bus.flag_err   = err_q;

endmodule

// File: tb/tb_compare_alarm_fsm.sv
// Directed-vector bench for compare_alarm_fsm: an 8-bit-count instance and a
// 2-bit-count instance receive the same stimulus.
module tb_compare_alarm_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_alarm_if #(.CNT_W(8)) bus8 ();
  compare_alarm_if #(.CNT_W(2)) bus2 ();

  compare_alarm_fsm #(.HI_COUNT(4), .LO_COUNT(4), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  compare_alarm_fsm #(.HI_COUNT(4), .LO_COUNT(4), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // flags = {equal, greater, less}; one clock, then settle past the edge
  task automatic drive(input logic v, input logic [7:0] smp, input logic [2:0] flags,
                       input logic clr);
    bus8.in_valid = v;   bus2.in_valid = v;
    bus8.sample   = smp; bus2.sample   = smp;
    bus8.equal    = flags[2]; bus2.equal   = flags[2];
    bus8.greater  = flags[1]; bus2.greater = flags[1];
    bus8.less     = flags[0]; bus2.less    = flags[0];
    bus8.clear    = clr; bus2.clear    = clr;
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  initial begin
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    rst = 1'b0;

    check("rst_state", 32'(bus8.state), 32'd0);
    check("rst_alarm", 32'(bus8.alarm), 32'd0);
    check("rst_rise",  32'(bus8.alarm_rise), 32'd0);
    check("rst_fall",  32'(bus8.alarm_fall), 32'd0);
    check("rst_over",  32'(bus8.over_count), 32'd0);
    check("rst_peak",  32'(bus8.peak), 32'd0);
    check("rst_err",   32'(bus8.flag_err), 32'd0);

    // four greater samples raise the alarm
    drive(1'b1, 8'h90, GT, 1'b0);
    check("t1_s1_state", 32'(bus8.state), 32'd1);
    drive(1'b1, 8'hA0, GT, 1'b0);
    drive(1'b1, 8'hFF, GT, 1'b0);
    check("t1_s3_state", 32'(bus8.state), 32'd1);
    check("t1_s3_alarm", 32'(bus8.alarm), 32'd0);
    drive(1'b1, 8'h81, GT, 1'b0);
    check("t1_s4_state", 32'(bus8.state), 32'd2);
    check("t1_s4_alarm", 32'(bus8.alarm), 32'd1);
    check("t1_s4_rise",  32'(bus8.alarm_rise), 32'd1);
    check("t1_peak",     32'(bus8.peak), 32'hFF);
    check("t1_over",     32'(bus8.over_count), 32'd4);
    check("t1_over_sat2", 32'(bus2.over_count), 32'd3);
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    check("t1_rise_1cyc", 32'(bus8.alarm_rise), 32'd0);
    check("t1_hold_alarm", 32'(bus8.alarm), 32'd1);

    // clearing run broken by greater, then a full clearing run
    drive(1'b1, 8'h01, LT, 1'b0);
    check("t3_l1_state", 32'(bus8.state), 32'd3);
    check("t3_l1_alarm", 32'(bus8.alarm), 32'd1);
    drive(1'b1, 8'h02, LT, 1'b0);
    drive(1'b1, 8'h03, LT, 1'b0);
    drive(1'b1, 8'h05, GT, 1'b0);
    check("t3_break_state", 32'(bus8.state), 32'd2);
    check("t3_break_alarm", 32'(bus8.alarm), 32'd1);
    check("t3_over", 32'(bus8.over_count), 32'd5);
    check("t3_peak_keep", 32'(bus8.peak), 32'hFF);
    drive(1'b1, 8'h01, LT, 1'b0);
    drive(1'b1, 8'h01, LT, 1'b0);
    drive(1'b1, 8'h01, LT, 1'b0);
    check("t3_l3_state", 32'(bus8.state), 32'd3);
    check("t3_l3_fall", 32'(bus8.alarm_fall), 32'd0);
    drive(1'b1, 8'h01, LT, 1'b0);
    check("t3_l4_state", 32'(bus8.state), 32'd0);
    check("t3_l4_alarm", 32'(bus8.alarm), 32'd0);
    check("t3_l4_fall",  32'(bus8.alarm_fall), 32'd1);
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    check("t3_fall_1cyc", 32'(bus8.alarm_fall), 32'd0);

    // clear discards a simultaneous greater sample
    drive(1'b1, 8'hEE, GT, 1'b1);
    check("clr_over", 32'(bus8.over_count), 32'd0);
    check("clr_peak", 32'(bus8.peak), 32'd0);
    check("clr_state", 32'(bus8.state), 32'd0);

    // equal breaks an arming run
    drive(1'b1, 8'h11, GT, 1'b0);
    drive(1'b1, 8'h22, GT, 1'b0);
    drive(1'b1, 8'h33, GT, 1'b0);
    drive(1'b1, 8'h40, EQ, 1'b0);
    check("t2_eq_state", 32'(bus8.state), 32'd0);
    check("t2_eq_alarm", 32'(bus8.alarm), 32'd0);
    drive(1'b1, 8'h44, GT, 1'b0);
    drive(1'b1, 8'h55, GT, 1'b0);
    drive(1'b1, 8'h66, GT, 1'b0);
    check("t2_s7_alarm", 32'(bus8.alarm), 32'd0);
    drive(1'b1, 8'h77, GT, 1'b0);
    check("t2_s8_alarm", 32'(bus8.alarm), 32'd1);
    check("t2_s8_rise",  32'(bus8.alarm_rise), 32'd1);
    check("t2_over",     32'(bus8.over_count), 32'd7);
    check("t2_peak",     32'(bus8.peak), 32'h77);

    // clear mid-ALARM drops alarm without a fall pulse
    drive(1'b0, 8'h00, 3'b000, 1'b1);
    check("clr_alarm_drop", 32'(bus8.alarm), 32'd0);
    check("clr_no_fall",    32'(bus8.alarm_fall), 32'd0);
    check("clr_idle",       32'(bus8.state), 32'd0);

    // gaps of in_valid=0 do not break the run
    drive(1'b1, 8'h10, GT, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'hFF, GT, 1'b0);
      drive(1'b0, 8'hFF, LT, 1'b0);
      check("t4_gap_state", 32'(bus8.state), 32'd1);
      check("t4_gap_over",  32'(bus8.over_count), 32'(k + 1));
      drive(1'b1, 8'(8'h20 + 8'(k) * 8'h10), GT, 1'b0);
    end
    check("t4_state", 32'(bus8.state), 32'd2);
    check("t4_rise",  32'(bus8.alarm_rise), 32'd1);
    check("t4_peak",  32'(bus8.peak), 32'h40);
    check("t4_over",  32'(bus8.over_count), 32'd4);

    // illegal flag combination only sets flag_err
    drive(1'b1, 8'hFF, 3'b011, 1'b0);
    check("t5_err",   32'(bus8.flag_err), 32'd1);
    check("t5_state", 32'(bus8.state), 32'd2);
    check("t5_over",  32'(bus8.over_count), 32'd4);
    check("t5_peak",  32'(bus8.peak), 32'h40);
    drive(1'b1, 8'h01, LT, 1'b0);
    check("t5_err_sticky", 32'(bus8.flag_err), 32'd1);
    drive(1'b0, 8'h00, 3'b000, 1'b1);
    check("t5_clr_err",   32'(bus8.flag_err), 32'd0);
    check("t5_clr_state", 32'(bus8.state), 32'd0);
    check("t5_clr_alarm", 32'(bus8.alarm), 32'd0);
    check("t5_clr_over",  32'(bus8.over_count), 32'd0);
    check("t5_clr_peak",  32'(bus8.peak), 32'd0);

    // 2-bit count saturates; rst mid-ALARM gives no fall pulse
    for (int k = 0; k < 5; k++) drive(1'b1, 8'h80, GT, 1'b0);
    check("t6_over2_sat", 32'(bus2.over_count), 32'd3);
    check("t6_over8",     32'(bus8.over_count), 32'd5);
    check("t6_alarm2",    32'(bus2.alarm), 32'd1);
    rst = 1'b1;
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    check("t6_rst_alarm", 32'(bus2.alarm), 32'd0);
    check("t6_rst_fall",  32'(bus2.alarm_fall), 32'd0);
    check("t6_rst_over",  32'(bus2.over_count), 32'd0);
    check("t6_rst_alarm8", 32'(bus8.alarm), 32'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 3'b000, 1'b0);
    check("t6_post_fall", 32'(bus8.alarm_fall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
